// File: rtl/hb_burst_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : hb_burst_driver_if
// Purpose  : Handshake, configuration and gate-drive bundle between the
//            register block (master) and the H-bridge burst driver (slave).
// Signals  : start/abort          - burst request / immediate termination
//            half_period          - clocks per half drive cycle (incl. dead)
//            dead_time            - all-off clocks at each half-cycle start
//            n_cycles             - full A+B drive cycles per burst
//            damp_len             - brake clocks after the burst, 0 = none
//            hlh/hll/hrh/hrl      - gate drives, active-high
//            busy/done/err        - status back to the register block
// Revision : 1.0 - initial release
// ============================================================================
interface hb_burst_driver_if #(
    parameter int HP_W = 8,
    parameter int DT_W = 4,
    parameter int NC_W = 8,
    parameter int DM_W = 8
);
    logic            start;
    logic            abort;
    logic [HP_W-1:0] half_period;
    logic [DT_W-1:0] dead_time;
    logic [NC_W-1:0] n_cycles;
    logic [DM_W-1:0] damp_len;
    logic            hlh;
    logic            hll;
    logic            hrh;
    logic            hrl;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, abort, half_period, dead_time, n_cycles, damp_len,
        input  hlh, hll, hrh, hrl, busy, done, err
    );

    modport slave (
        input  start, abort, half_period, dead_time, n_cycles, damp_len,
        output hlh, hll, hrh, hrl, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/hb_burst_driver.sv
`default_nettype none
// ============================================================================
// Module   : hb_burst_driver
// Purpose  : H-bridge transmit ping burst generator. Produces n_cycles full
//            A/B drive cycles of half_period clocks each, with dead_time
//            all-off clocks at the start of every half cycle, followed by an
//            optional brake interval (dead_time off, then damp_len brake).
// Ports    : clk  - system clock (HSOSC)
//            rst  - asynchronous active-low reset
//            bus  - slave side of hb_burst_driver_if (handshake, config,
//                   registered gate drives and status)
// Revision : 1.0 - initial release
// ============================================================================
module hb_burst_driver #(
    parameter int HP_W = 8,
    parameter int DT_W = 4,
    parameter int NC_W = 8,
    parameter int DM_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    hb_burst_driver_if.slave  bus
);

    // Common width for half-period/dead-time comparisons, one bit wider so
    // the incremented count can never alias.
    localparam int HW = ((HP_W > DT_W) ? HP_W : DT_W) + 1;
    localparam int CW = NC_W + 1;
    localparam int MW = DM_W + 1;

    // Gate codes packed as {hlh, hll, hrh, hrl}
    localparam logic [3:0] c_GATES_OFF   = 4'b0000;
    localparam logic [3:0] c_GATES_A     = 4'b1001;
    localparam logic [3:0] c_GATES_B     = 4'b0110;
    localparam logic [3:0] c_GATES_BRAKE = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEAD    = 3'd1,
        ST_DRIVE_A = 3'd2,
        ST_DRIVE_B = 3'd3,
        ST_DAMP    = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    // Which section the current DEAD interval precedes
    typedef enum logic [1:0] {
        SEC_A    = 2'd0,
        SEC_B    = 2'd1,
        SEC_DAMP = 2'd2
    } sec_t;

    state_t          state_q,   state_d;
    sec_t            sec_q,     sec_d;
    logic [HP_W-1:0] hp_q,      hp_d;
    logic [DT_W-1:0] dt_q,      dt_d;
    logic [NC_W-1:0] nc_q,      nc_d;
    logic [DM_W-1:0] dm_q,      dm_d;
    logic [HP_W-1:0] hp_cnt_q,  hp_cnt_d;
    logic [NC_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [DM_W-1:0] dm_cnt_q,  dm_cnt_d;
    logic [3:0]      gates_q,   gates_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic            err_q,     err_d;

    logic [HW-1:0]   w_hp_inc;
    logic            w_hp_end;
    logic            w_dead_end;
    logic            w_cyc_last;
    logic            w_dm_last;
    logic            w_cfg_ok;

    // Terminal-count tests are made on the current count before it is
    // incremented, so no counter ever has to wrap.
    assign w_hp_inc   = HW'(hp_cnt_q) + HW'(1);
    assign w_hp_end   = (w_hp_inc == HW'(hp_q));
    assign w_dead_end = (w_hp_inc == HW'(dt_q));
    assign w_cyc_last = ((CW'(cyc_cnt_q) + CW'(1)) == CW'(nc_q));
    assign w_dm_last  = ((MW'(dm_cnt_q) + MW'(1)) == MW'(dm_q));
    assign w_cfg_ok   = (HW'(bus.half_period) > HW'(bus.dead_time));

    // First state of a section: its dead interval, or straight into the
    // active part when dead time is zero.
    function automatic state_t enter_state(input sec_t sec, input logic dt_zero);
        state_t s;
        if (!dt_zero)             s = ST_DEAD;
        else if (sec == SEC_DAMP) s = ST_DAMP;
        else if (sec == SEC_A)    s = ST_DRIVE_A;
        else                      s = ST_DRIVE_B;
        return s;
    endfunction

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        hp_d      = hp_q;
        dt_d      = dt_q;
        nc_d      = nc_q;
        dm_d      = dm_q;
        hp_cnt_d  = hp_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        dm_cnt_d  = dm_cnt_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Abort together with start cancels the request outright.
                if (bus.start && !bus.abort) begin
                    if (w_cfg_ok) begin
                        hp_d      = bus.half_period;
                        dt_d      = bus.dead_time;
                        nc_d      = bus.n_cycles;
                        dm_d      = bus.damp_len;
                        hp_cnt_d  = '0;
                        cyc_cnt_d = '0;
                        dm_cnt_d  = '0;
                        if (bus.n_cycles != '0) begin
                            sec_d   = SEC_A;
                            state_d = enter_state(SEC_A, bus.dead_time == '0);
                        end else if (bus.damp_len != '0) begin
                            sec_d   = SEC_DAMP;
                            state_d = enter_state(SEC_DAMP, bus.dead_time == '0);
                        end else begin
                            state_d = ST_FIN;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_DEAD: begin
                if (bus.abort) begin
                    state_d = ST_FIN;
                end else begin
                    // The dead clocks are part of the half period, so the
                    // half-period count keeps running through them.
                    hp_cnt_d = hp_cnt_q + HP_W'(1);
                    if (w_dead_end) begin
                        if (sec_q == SEC_DAMP)   state_d = ST_DAMP;
                        else if (sec_q == SEC_A) state_d = ST_DRIVE_A;
                        else                     state_d = ST_DRIVE_B;
                    end
                end
            end

            ST_DRIVE_A: begin
                if (bus.abort) begin
                    state_d = ST_FIN;
                end else if (w_hp_end) begin
                    hp_cnt_d = '0;
                    sec_d    = SEC_B;
                    state_d  = enter_state(SEC_B, dt_q == '0);
                end else begin
                    hp_cnt_d = hp_cnt_q + HP_W'(1);
                end
            end

            ST_DRIVE_B: begin
                if (bus.abort) begin
                    state_d = ST_FIN;
                end else if (w_hp_end) begin
                    hp_cnt_d = '0;
                    if (w_cyc_last) begin
                        if (dm_q != '0) begin
                            dm_cnt_d = '0;
                            sec_d    = SEC_DAMP;
                            state_d  = enter_state(SEC_DAMP, dt_q == '0);
                        end else begin
                            state_d = ST_FIN;
                        end
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + NC_W'(1);
                        sec_d     = SEC_A;
                        state_d   = enter_state(SEC_A, dt_q == '0);
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + HP_W'(1);
                end
            end

            ST_DAMP: begin
                if (bus.abort || w_dm_last) begin
                    state_d = ST_FIN;
                end else begin
                    dm_cnt_d = dm_cnt_q + DM_W'(1);
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so the gate
    // flops always match the state they belong to and no input reaches a
    // gate combinationally.
    always_comb begin
        gates_d = c_GATES_OFF;
        case (state_d)
            ST_DRIVE_A: gates_d = c_GATES_A;
            ST_DRIVE_B: gates_d = c_GATES_B;
            ST_DAMP:    gates_d = c_GATES_BRAKE;
            default:    gates_d = c_GATES_OFF;
        endcase
        busy_d = (state_d != ST_IDLE) && (state_d != ST_FIN);
        done_d = (state_d == ST_FIN);
    end

    // Asynchronous reset drops the gates immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sec_q     <= SEC_A;
            hp_q      <= '0;
            dt_q      <= '0;
            nc_q      <= '0;
            dm_q      <= '0;
            hp_cnt_q  <= '0;
            cyc_cnt_q <= '0;
            dm_cnt_q  <= '0;
            gates_q   <= c_GATES_OFF;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            hp_q      <= hp_d;
            dt_q      <= dt_d;
            nc_q      <= nc_d;
            dm_q      <= dm_d;
            hp_cnt_q  <= hp_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            dm_cnt_q  <= dm_cnt_d;
            gates_q   <= gates_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.hlh  = gates_q[3];
    assign bus.hll  = gates_q[2];
    assign bus.hrh  = gates_q[1];
    assign bus.hrl  = gates_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule
`default_nettype wire
